// File: rtl/stash_ctrl_pkg.sv
// Shared types and defaults for the lap Stash controller and the Stash it drives.
package stash_ctrl_pkg;

    localparam int STASH_DEPTH = 5;
    localparam int STASH_WIDTH = 8;

    typedef enum logic [2:0] {
        LIVE,
        CAPTURE,
        SEEK,
        BROWSE,
        CLEAR
    } state_t;

    // Width of a slot index; a one-slot Stash still needs a 1-bit pointer.
    function automatic int slot_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stash_ctrl_timeout.sv
// Browse idle timer: held loaded while not enabled, counts down while enabled,
// and flags expiry on the last of TIMEOUT_CYC enabled cycles.
module stash_ctrl_timeout #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TW-1:0] remain;

    always_ff @(posedge clk) begin
        if (reset) begin
            remain <= TW'(TIMEOUT_CYC - 1);
        end else if (load) begin
            remain <= TW'(TIMEOUT_CYC - 1);
        end else if (en && remain != '0) begin
            remain <= remain - TW'(1);
        end
    end

    assign expire = en && (remain == '0);

endmodule

// File: rtl/stash_ctrl.sv
// Lap/browse/clear sequencer for the Stash circular buffer: mirrors the Stash
// pointers and steps its read pointer so the display walks laps oldest-first.
module stash_ctrl
    import stash_ctrl_pkg::*;
#(
    parameter int DEPTH       = STASH_DEPTH,
    parameter int WIDTH       = STASH_WIDTH,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       lap_btn,
    input  logic                       browse_btn,
    input  logic                       clear_btn,
    input  logic [WIDTH-1:0]           time_in,
    output logic [WIDTH-1:0]           sample_in,
    output logic                       sample_in_valid,
    output logic                       next_sample,
    output logic                       stash_reset,
    output logic                       show_stash,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [slot_w(DEPTH)-1:0]   browse_idx
);

    localparam int SW = slot_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    state_t          state, state_d;
    logic [SW-1:0]   wr_slot, wr_d;
    logic [SW-1:0]   rd_slot, rd_d;
    logic [SW-1:0]   target_slot, tgt_d;
    logic [SW-1:0]   idx_d, idx_nxt, tgt_nxt, oldest;
    logic [CW-1:0]   count_d;
    logic [WIDTH-1:0] sample_in_d;
    logic            siv_d, ns_d, srst_d, show_d;
    logic            full, expire, tmo_load, tmo_en;

    function automatic logic [SW-1:0] slot_add(input logic [SW-1:0] a,
                                               input logic [SW-1:0] b);
        int s;
        s = int'(a) + int'(b);
        if (s >= DEPTH) s = s - DEPTH;
        return SW'(s);
    endfunction

    assign full   = (count == CW'(DEPTH));
    // Once the buffer has wrapped, the oldest lap sits where the next write lands.
    assign oldest = full ? wr_slot : '0;

    assign tmo_en   = (state == BROWSE);
    assign tmo_load = (state != BROWSE) || browse_btn;

    stash_ctrl_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .load  (tmo_load),
        .en    (tmo_en),
        .expire(expire)
    );

    always_comb begin
        state_d     = state;
        sample_in_d = sample_in;
        siv_d       = 1'b0;
        ns_d        = 1'b0;
        srst_d      = 1'b0;
        show_d      = 1'b0;
        count_d     = count;
        wr_d        = wr_slot;
        rd_d        = rd_slot;
        idx_d       = browse_idx;
        tgt_d       = target_slot;
        idx_nxt     = '0;
        tgt_nxt     = '0;

        // Track whatever the Stash is doing this cycle, regardless of the next state,
        // so an aborted seek leaves rd_slot matching the pulses actually issued.
        if (next_sample) rd_d = slot_add(rd_slot, SW'(1));
        if (sample_in_valid) begin
            wr_d = slot_add(wr_slot, SW'(1));
            if (!full) count_d = count + CW'(1);
        end

        if (clear_btn) begin
            state_d = CLEAR;
            srst_d  = 1'b1;
            count_d = '0;
            wr_d    = '0;
            rd_d    = '0;
            idx_d   = '0;
            tgt_d   = '0;
        end else if (lap_btn) begin
            state_d     = CAPTURE;
            siv_d       = 1'b1;
            sample_in_d = time_in;
        end else begin
            case (state)
                LIVE: begin
                    if (browse_btn && count != '0) begin
                        idx_d = '0;
                        tgt_d = oldest;
                        if (rd_slot == oldest) begin
                            state_d = BROWSE;
                            show_d  = 1'b1;
                        end else begin
                            state_d = SEEK;
                            ns_d    = 1'b1;
                        end
                    end
                end
                CAPTURE, CLEAR: state_d = LIVE;
                SEEK: begin
                    // Pulses alternate with idle cycles; decide only on the idle ones.
                    if (!next_sample) begin
                        if (rd_slot == target_slot) begin
                            state_d = BROWSE;
                            show_d  = 1'b1;
                        end else begin
                            ns_d = 1'b1;
                        end
                    end
                end
                BROWSE: begin
                    show_d = 1'b1;
                    if (browse_btn) begin
                        if (int'(browse_idx) + 1 >= int'(count)) idx_nxt = '0;
                        else                                     idx_nxt = browse_idx + SW'(1);
                        tgt_nxt = slot_add(oldest, idx_nxt);
                        idx_d   = idx_nxt;
                        tgt_d   = tgt_nxt;
                        if (rd_slot != tgt_nxt) begin
                            state_d = SEEK;
                            show_d  = 1'b0;
                            ns_d    = 1'b1;
                        end
                    end else if (expire) begin
                        state_d = LIVE;
                        show_d  = 1'b0;
                    end
                end
                default: state_d = LIVE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= LIVE;
            sample_in       <= '0;
            sample_in_valid <= 1'b0;
            next_sample     <= 1'b0;
            stash_reset     <= 1'b0;
            show_stash      <= 1'b0;
            count           <= '0;
            browse_idx      <= '0;
            wr_slot         <= '0;
            rd_slot         <= '0;
            target_slot     <= '0;
        end else begin
            state           <= state_d;
            sample_in       <= sample_in_d;
            sample_in_valid <= siv_d;
            next_sample     <= ns_d;
            stash_reset     <= srst_d;
            show_stash      <= show_d;
            count           <= count_d;
            browse_idx      <= idx_d;
            wr_slot         <= wr_d;
            rd_slot         <= rd_d;
            target_slot     <= tgt_d;
        end
    end

endmodule

// File: tb/tb_stash_ctrl.sv
// Directed bench for stash_ctrl with a behavioural Stash model driving the display mux.
module tb_stash_ctrl;

    localparam int DEPTH = 5;
    localparam int TOUT  = 1000;

    logic       clk = 1'b0;
    logic       reset, lap_btn, browse_btn, clear_btn;
    logic [7:0] time_in, sample_in;
    logic       sample_in_valid, next_sample, stash_reset, show_stash;
    logic [2:0] count, browse_idx;

    int tests = 0;
    int errors = 0;

    stash_ctrl #(.DEPTH(DEPTH), .WIDTH(8), .TIMEOUT_CYC(TOUT)) dut (
        .clk            (clk),
        .reset          (reset),
        .lap_btn        (lap_btn),
        .browse_btn     (browse_btn),
        .clear_btn      (clear_btn),
        .time_in        (time_in),
        .sample_in      (sample_in),
        .sample_in_valid(sample_in_valid),
        .next_sample    (next_sample),
        .stash_reset    (stash_reset),
        .show_stash     (show_stash),
        .count          (count),
        .browse_idx     (browse_idx)
    );

    always #5 clk = ~clk;

    // Stash behaviour as the controller expects it
    logic [7:0] smem [0:DEPTH-1];
    int swr, srd;
    always @(posedge clk) begin
        if (reset || stash_reset) begin
            swr <= 0;
            srd <= 0;
        end else begin
            if (sample_in_valid) begin
                smem[swr] <= sample_in;
                swr <= (swr + 1) % DEPTH;
            end
            if (next_sample) srd <= (srd + 1) % DEPTH;
        end
    end
    wire [7:0] disp = show_stash ? smem[srd] : time_in;

    typedef struct {
        logic       lap, brw, clr;
        logic [7:0] tin;
        logic       siv, ns, srst, show;
        int         cnt, idx;
        logic [7:0] smp, dsp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic lap, input logic brw, input logic clr, input int tin,
                                input logic siv, input logic ns, input logic srst, input logic show,
                                input int cnt, input int idx, input int smp, input int dsp);
        vec_t v;
        v.lap = lap; v.brw = brw; v.clr = clr; v.tin = 8'(tin);
        v.siv = siv; v.ns = ns; v.srst = srst; v.show = show;
        v.cnt = cnt; v.idx = idx; v.smp = 8'(smp); v.dsp = 8'(dsp);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle();
        lap_btn = 0; browse_btn = 0; clear_btn = 0; time_in = 0;
    endtask

    // Press browse, follow the seek, and check pulse count, latency, display and index.
    task automatic do_browse(input string nm, input int exp_k, input int exp_disp, input int exp_idx);
        int   cyc, pulses;
        logic prev_ns;
        bit   shape_ok;
        browse_btn = 1;
        step();
        browse_btn = 0;
        cyc = 1; pulses = 0; prev_ns = 0; shape_ok = 1;
        while (!show_stash && cyc < 40) begin
            if (next_sample) begin
                pulses++;
                if (prev_ns) shape_ok = 0;
            end
            if (next_sample && sample_in_valid) shape_ok = 0;
            prev_ns = next_sample;
            step();
            cyc++;
        end
        check({nm, ".pulses"}, pulses, exp_k);
        check({nm, ".latency"}, cyc, 2 * exp_k + 1);
        check({nm, ".disp"}, int'(disp), exp_disp);
        check({nm, ".idx"}, int'(browse_idx), exp_idx);
        check({nm, ".pulse_shape"}, int'(shape_ok), 1);
    endtask

    initial begin
        logic [27:0] act, exp;
        bit ok;

        reset = 1; idle();
        step(); step();
        check("reset_state", int'({sample_in_valid, next_sample, stash_reset, show_stash,
                                   count, browse_idx, sample_in}), 0);
        reset = 0;

        //            lap brw clr tin | siv ns srst show cnt idx smp dsp
        vecs.push_back(mk(1, 0, 0, 17,  1, 0, 0, 0,  0, 0, 17, 17));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0,  1, 0, 17, 0));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0,  1, 0, 17, 0));
        vecs.push_back(mk(0, 0, 1, 0,   0, 0, 1, 0,  0, 0, 17, 0));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 17, 0));
        vecs.push_back(mk(1, 0, 0, 10,  1, 0, 0, 0,  0, 0, 10, 10));
        vecs.push_back(mk(1, 0, 0, 20,  1, 0, 0, 0,  1, 0, 20, 20));
        vecs.push_back(mk(1, 0, 0, 30,  1, 0, 0, 0,  2, 0, 30, 30));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0,  3, 0, 30, 0));
        vecs.push_back(mk(0, 1, 0, 0,   0, 0, 0, 1,  3, 0, 30, 10));
        vecs.push_back(mk(0, 1, 0, 0,   0, 1, 0, 0,  3, 1, 30, 0));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0,  3, 1, 30, 0));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 1,  3, 1, 30, 20));
        vecs.push_back(mk(0, 1, 0, 0,   0, 1, 0, 0,  3, 2, 30, 0));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0,  3, 2, 30, 0));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 1,  3, 2, 30, 30));
        vecs.push_back(mk(0, 1, 0, 0,   0, 1, 0, 0,  3, 0, 30, 0));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0,  3, 0, 30, 0));
        vecs.push_back(mk(0, 0, 0, 0,   0, 1, 0, 0,  3, 0, 30, 0));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0,  3, 0, 30, 0));
        vecs.push_back(mk(0, 0, 0, 0,   0, 1, 0, 0,  3, 0, 30, 0));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0,  3, 0, 30, 0));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 1,  3, 0, 30, 10));

        foreach (vecs[i]) begin
            lap_btn = vecs[i].lap; browse_btn = vecs[i].brw;
            clear_btn = vecs[i].clr; time_in = vecs[i].tin;
            step();
            act = {sample_in_valid, next_sample, stash_reset, show_stash,
                   4'(count), 4'(browse_idx), sample_in, disp};
            exp = {vecs[i].siv, vecs[i].ns, vecs[i].srst, vecs[i].show,
                   4'(vecs[i].cnt), 4'(vecs[i].idx), vecs[i].smp, vecs[i].dsp};
            tests++;
            if (act !== exp) begin
                errors++;
                $display("FAIL vec%0d: got %h, expected %h", i, act, exp);
            end
        end
        idle();

        // Seven laps into five slots: count saturates, oldest is slot 2
        clear_btn = 1; step(); clear_btn = 0; step();
        for (int i = 0; i < 7; i++) begin
            lap_btn = 1; time_in = 8'(i); step();
            lap_btn = 0; time_in = 0; step();
        end
        check("sat_count", int'(count), 5);
        do_browse("full0", 2, 2, 0);
        do_browse("full1", 1, 3, 1);
        do_browse("full2", 1, 4, 2);
        do_browse("full3", 1, 5, 3);
        do_browse("full4", 1, 6, 4);
        do_browse("full_wrap", 1, 2, 0);

        // Idle timeout returns to live display, next browse restarts at the oldest
        do_browse("pre_tmo", 1, 3, 1);
        for (int i = 0; i < TOUT - 1; i++) step();
        check("tmo_still_shown", int'(show_stash), 1);
        step();
        check("tmo_expired", int'(show_stash), 0);
        do_browse("post_tmo", 4, 2, 0);

        // clear and lap together while seeking: clear wins, nothing written
        browse_btn = 1; step(); browse_btn = 0;
        check("seek_pulse", int'(next_sample), 1);
        clear_btn = 1; lap_btn = 1; time_in = 8'd99; step();
        clear_btn = 0; lap_btn = 0; time_in = 0;
        check("clr_srst", int'(stash_reset), 1);
        check("clr_no_write", int'(sample_in_valid), 0);
        check("clr_count", int'(count), 0);
        ok = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (sample_in_valid || stash_reset) ok = 0;
        end
        check("clr_quiet", int'(ok), 1);
        browse_btn = 1; step(); browse_btn = 0;
        ok = 1;
        for (int i = 0; i < 6; i++) begin
            if (show_stash || next_sample) ok = 0;
            step();
        end
        check("empty_browse_ignored", int'(ok), 1);

        // Reset in the middle of a long seek
        lap_btn = 1; time_in = 8'd40; step(); lap_btn = 0; time_in = 0; step();
        lap_btn = 1; time_in = 8'd50; step(); lap_btn = 0; time_in = 0; step();
        do_browse("k0", 0, 40, 0);
        do_browse("second", 1, 50, 1);
        browse_btn = 1; step(); browse_btn = 0;
        check("long_seek_pulse", int'(next_sample), 1);
        step();
        reset = 1; step(); reset = 0;
        check("mid_seek_reset", int'({sample_in_valid, next_sample, stash_reset, show_stash,
                                      count, browse_idx, sample_in}), 0);
        ok = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (next_sample || show_stash || sample_in_valid) ok = 0;
        end
        check("post_reset_quiet", int'(ok), 1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
